lint_stim_gen: RTL and testbench
================================

Name: lint_stim_gen

Overview:
Lint-clean stimulus generator that drives the two-, three- and four-bit data lanes and the check qualifier consumed by the lint lab datapath block. This block is the transmitter side of that interface.
- On a start pulse it emits a burst of len 9-bit vectors, split across the three lanes, using a valid/stall handshake.
- Vectors are either incrementing or LFSR-generated.
- Every output is registered, with asynchronous active-low reset.

Parameters:
SEED, 9'h1A5, LFSR start value. SEED==0 is replaced by 9'h001.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  reset, asynchronous, active-low
start  input  1  burst request, sampled only in IDLE
mode  input  1  0 = incrementing, 1 = LFSR; sampled with start
len  input  8  vectors per burst; sampled with start
stall  input  1  consumer not ready; holds the current vector
data_out1  output  2  W[1:0]
data_out2  output  3  W[4:2]
data_out3  output  4  W[8:5]
check_out  output  1  even-parity bit of W (XOR of W[8:0])
vld  output  1  lanes carry a valid vector
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at burst end
vec_cnt  output  8  vectors accepted in the current or last burst

Behaviour:
- Reset, asynchronous, active-low, effective any time including mid-burst:
  - state = IDLE.
  - W = 0; all outputs = 0; vec_cnt = 0.
  - mode_q = 0; len_q = 0.
- State machine: IDLE, RUN, DONE.
- IDLE:
  - If start=1 and len!=0 → RUN: capture mode_q and len_q, clear vec_cnt, load W.
  - W loads 0 when mode=0, SEED when mode=1.
  - If start=1 and len==0 → DONE directly: vec_cnt cleared, vld never asserts.
- RUN:
  - vld=1; lanes and check_out present W.
  - A vector is accepted on each clock edge where stall=0. On acceptance, vec_cnt increments.
  - If vec_cnt+1 == len_q → DONE, vld=0. Otherwise W advances.
  - stall=1: W, lanes, check_out, vld and vec_cnt all hold.
- DONE: done=1 for exactly one cycle, vld=0, then IDLE. vec_cnt holds its final value (== len_q) until the next accepted start.
- busy = 1 in RUN and DONE.
- Latency: first vector appears the cycle after start is sampled. done rises the cycle after the last accepted vector.
- Incrementing mode: W_next = W + 1, modulo 512. Wraps 9'h1FF → 9'h000 with no flag.
- LFSR mode: Fibonacci polynomial x^9+x^5+1, W_next = {W[7:0], W[8]^W[4]}. The all-zero state is never reached from a nonzero seed.
- Lanes and check_out:
  - Are registered together with W, so they are always mutually consistent.
  - Are forced to 0 when vld=0.
- start while busy=1 is ignored; the burst is not restarted and no inputs are re-sampled.
- mode, len and stall changes mid-burst:
  - mode and len changes have no effect; stall is honoured every cycle.
  - stall during DONE or IDLE has no effect.
- Design rules:
  - No latches.
  - Every signal has a single driver.
  - Full case coverage with defaults.
  - Non-blocking assignments in sequential logic only.
  - All widths match exactly; explicit sized constants.

Test Plan:
- Reset, then mode=0, len=4, start pulse, stall=0:
  - vld high for 4 cycles; W = 0,1,2,3 → data_out1 = 0,1,2,3, data_out2 = 0, data_out3 = 0, check_out = 0,1,1,0.
  - done pulses the next cycle; vec_cnt = 4; busy drops after done.
- mode=1, len=2, SEED=9'h1A5:
  - Vector 0: data_out1=2'b01, data_out2=3'b001, data_out3=4'hD, check_out=1.
  - Vector 1: W=9'h14B → data_out1=2'b11, data_out2=3'b010, data_out3=4'hA, check_out=1.
  - done after 2 vectors.
- mode=0, len=3, stall high for 2 cycles while W=1:
  - W=1 is held for 3 cycles; total vld cycles = 5.
  - Sequence 0,1,1,1,2; vec_cnt ends at 3.
- len=0 start: no vld; done pulses one cycle after start; vec_cnt = 0.
- Second start pulse mid-burst (len=5): ignored; exactly 5 vectors, single done.
- Reset asserted at vector 2 of 6: all outputs 0 immediately (asynchronous). After release, state is IDLE and a new start with len=1 produces W=0 with a single done.

Source files
------------

// File: rtl/lint_stim_gen.sv
// Burst stimulus generator for the lint lab datapath lanes.
// Emits len 9-bit vectors (incrementing or LFSR) under a valid/stall handshake.
module lint_stim_gen #(
  parameter logic [8:0] SEED = 9'h1A5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] len,
  input  logic       stall,
  output logic [1:0] data_out1,
  output logic [2:0] data_out2,
  output logic [3:0] data_out3,
  output logic       check_out,
  output logic       vld,
  output logic       busy,
  output logic       done,
  output logic [7:0] vec_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // An all-zero seed would lock the LFSR at zero.
  localparam logic [8:0] SEED_EFF = (SEED == 9'd0) ? 9'd1 : SEED;

  state_t     state;
  state_t     state_n;
  logic [8:0] w;
  logic [8:0] w_n;
  logic [8:0] w_adv;
  logic       mode_q;
  logic       mode_n;
  logic [7:0] len_q;
  logic [7:0] len_n;
  logic [7:0] cnt_n;
  logic [7:0] cnt_inc;
  logic       vld_n;
  logic       done_n;

  assign cnt_inc = vec_cnt + 8'd1;
  assign w_adv   = mode_q ? {w[7:0], w[8] ^ w[4]}
                          : w + 9'd1;

  always_comb begin
    state_n = state;
    w_n     = w;
    mode_n  = mode_q;
    len_n   = len_q;
    cnt_n   = vec_cnt;
    vld_n   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_n = 8'd0;
          if (len != 8'd0) begin
            state_n = RUN;
            mode_n  = mode;
            len_n   = len;
            w_n     = mode ? SEED_EFF : 9'd0;
            vld_n   = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end
      RUN: begin
        vld_n = 1'b1;
        if (!stall) begin
          cnt_n = cnt_inc;
          if (cnt_inc == len_q) begin
            state_n = DONE;
            vld_n   = 1'b0;
            done_n  = 1'b1;
          end else begin
            w_n = w_adv;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Lanes are built from the next W so they stay aligned with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      w         <= 9'd0;
      mode_q    <= 1'b0;
      len_q     <= 8'd0;
      vec_cnt   <= 8'd0;
      vld       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      data_out1 <= 2'd0;
      data_out2 <= 3'd0;
      data_out3 <= 4'd0;
      check_out <= 1'b0;
    end else begin
      state     <= state_n;
      w         <= w_n;
      mode_q    <= mode_n;
      len_q     <= len_n;
      vec_cnt   <= cnt_n;
      vld       <= vld_n;
      done      <= done_n;
      busy      <= (state_n != IDLE);
      data_out1 <= vld_n ? w_n[1:0] : 2'd0;
      data_out2 <= vld_n ? w_n[4:2] : 3'd0;
      data_out3 <= vld_n ? w_n[8:5] : 4'd0;
      check_out <= vld_n & (^w_n);
    end
  end

endmodule

// File: tb/tb_lint_stim_gen.sv
// Scoreboard bench for lint_stim_gen.
// Random and directed bursts checked against a queue-based reference model.
module tb_lint_stim_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] len;
  logic       stall;
  logic [1:0] data_out1;
  logic [2:0] data_out2;
  logic [3:0] data_out3;
  logic       check_out;
  logic       vld;
  logic       busy;
  logic       done;
  logic [7:0] vec_cnt;

  lint_stim_gen #(.SEED(9'h1A5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mode(mode),
    .len(len),
    .stall(stall),
    .data_out1(data_out1),
    .data_out2(data_out2),
    .data_out3(data_out3),
    .check_out(check_out),
    .vld(vld),
    .busy(busy),
    .done(done),
    .vec_cnt(vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int vld_cycles = 0;
  int cur_len = 0;
  int exp_q[$];
  int done_q[$];
  bit prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
               name, act, act, req, req, $time);
    end
  endtask

  // Reference: the whole burst is computed up front with plain arithmetic.
  task automatic model_burst(input bit m, input int l);
    int v;
    v = m ? 'h1A5 : 0;
    cur_len = l;
    for (int k = 0; k < l; k++) begin
      exp_q.push_back(v);
      if (m) v = ((v * 2) % 512) + (((v >> 8) ^ (v >> 4)) & 1);
      else   v = (v + 1) % 512;
    end
    done_q.push_back(l);
  endtask

  function automatic int par9(input int v);
    int p;
    p = 0;
    for (int i = 0; i < 9; i++) p = p ^ ((v >> i) & 1);
    return p;
  endfunction

  // Monitor: compares every presented vector; pops on acceptance.
  always @(negedge clk) begin
    if (reset) begin
      if (vld) begin
        vld_cycles++;
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", 1, 0);
        end else begin
          chk("lanes", {data_out3, data_out2, data_out1}, exp_q[0]);
          chk("check_out", check_out, par9(exp_q[0]));
          chk("vec_cnt_run", vec_cnt, cur_len - exp_q.size());
          chk("busy_run", busy, 1);
          if (!stall) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_lanes_zero",
            {data_out3, data_out2, data_out1, check_out}, 0);
      end
      if (done) begin
        chk("done_single", prev_done, 0);
        chk("done_vld_low", vld, 0);
        chk("done_busy", busy, 1);
        chk("done_vectors_left", exp_q.size(), 0);
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_vec_cnt", vec_cnt, done_q.pop_front());
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (busy) chk("timeout_busy", 1, 0);
  endtask

  task automatic run_burst(input bit m, input int l,
                           input int stall_pct, input bit restart);
    int cyc;
    @(posedge clk); #1;
    mode = m; len = 8'(l); start = 1'b1; stall = 1'b0;
    model_burst(m, l);
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); len = 8'($urandom);
    @(negedge clk);
    chk("first_vld_latency", vld, (l != 0) ? 1 : 0);
    chk("len0_done_latency", done, (l == 0) ? 1 : 0);
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk); #1;
      if (!busy) break;
      stall = ($urandom_range(99) < stall_pct);
      start = (restart && cyc == 2);
      len = 8'($urandom_range(1, 20));
      cyc++;
    end
    start = 1'b0; stall = 1'b0;
    if (busy) chk("timeout_burst", 1, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_drained", done_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0; len = 8'd0; stall = 1'b0;
    #23;
    chk("reset_out", {data_out3, data_out2, data_out1, check_out,
                      vld, busy, done}, 0);
    chk("reset_vec_cnt", vec_cnt, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    vld_cycles = 0;
    run_burst(1'b0, 4, 0, 1'b0);
    chk("inc4_vld_cycles", vld_cycles, 4);
    chk("inc4_vec_cnt", vec_cnt, 4);

    run_burst(1'b1, 2, 0, 1'b0);
    chk("lfsr2_vec_cnt", vec_cnt, 2);

    // Hold W=1 for three cycles with a two-cycle stall.
    vld_cycles = 0;
    @(posedge clk); #1;
    mode = 1'b0; len = 8'd3; start = 1'b1;
    model_burst(1'b0, 3);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #1 stall = 1'b0;
    wait_idle();
    chk("stall_vld_cycles", vld_cycles, 5);
    chk("stall_vec_cnt", vec_cnt, 3);

    run_burst(1'b0, 0, 0, 1'b0);
    chk("len0_vec_cnt", vec_cnt, 0);

    vld_cycles = 0;
    run_burst(1'b0, 5, 0, 1'b1);
    chk("restart_vld_cycles", vld_cycles, 5);

    // Asynchronous reset in the middle of a six-vector burst.
    @(posedge clk); #1;
    mode = 1'b0; len = 8'd6; start = 1'b1;
    model_burst(1'b0, 6);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_w2", {data_out3, data_out2, data_out1}, 2);
    reset = 1'b0;
    exp_q.delete();
    done_q.delete();
    #1;
    chk("async_reset_out", {data_out3, data_out2, data_out1, check_out,
                            vld, busy, done}, 0);
    chk("async_reset_cnt", vec_cnt, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    vld_cycles = 0;
    run_burst(1'b0, 1, 0, 1'b0);
    chk("post_reset_vld_cycles", vld_cycles, 1);

    for (int i = 0; i < 25; i++) begin
      int l;
      l = (i % 5 == 4) ? $urandom_range(30, 60) : $urandom_range(0, 12);
      run_burst(1'($urandom), l, 30, 1'($urandom));
      chk("rand_vec_cnt", vec_cnt, l);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
